// File: rtl/decode_pkg.sv
// Shared types and constants for the KGP-RISC decode stage.
// Contents: the instruction class enum, opcode values, instruction field bit
// positions, and the packed struct of decoded fields produced by decode_fields.
package decode_pkg;

  typedef enum logic [2:0] {
    ALU_R   = 3'd0,
    ALU_I   = 3'd1,
    LOAD    = 3'd2,
    STORE   = 3'd3,
    BRANCH  = 3'd4,
    JUMP    = 3'd5,
    ILLEGAL = 3'd7
  } instr_class_t;

  localparam logic [5:0] OP_ALU_R  = 6'd0;
  localparam logic [5:0] OP_ALU_I  = 6'd1;
  localparam logic [5:0] OP_LOAD   = 6'd2;
  localparam logic [5:0] OP_STORE  = 6'd3;
  localparam logic [5:0] OP_BRANCH = 6'd4;
  localparam logic [5:0] OP_JUMP   = 6'd5;

  // Field positions (fixed for a 32-bit instruction word).
  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam int RD_HI  = 25;
  localparam int RD_LO  = 21;
  localparam int RS_HI  = 20;
  localparam int RS_LO  = 16;
  localparam int SH_HI  = 15;
  localparam int SH_LO  = 11;
  localparam int EXT_HI = 10;
  localparam int EXT_LO = 0;
  localparam int IMM_HI = 20;
  localparam int OFF_HI = 25;

  // Width-independent part of a decoded entry; PC and the XLEN-wide
  // sign-extended values are carried next to it in the stage.
  typedef struct packed {
    logic [5:0]   opcode;
    logic [4:0]   rd;
    logic [4:0]   rs;
    logic [4:0]   shamt;
    logic [10:0]  ext;
    instr_class_t cls;
    logic         illegal;
  } dec_fields_t;

endpackage

// File: rtl/decode_stage_fields.sv
// decode_fields: purely combinational instruction splitter and classifier.
// Ports:
//   instr  in  IW    raw instruction (bits above 31 ignored)
//   fields out       opcode/rd/rs/shamt/ext, class and illegal flag
//   imm    out XLEN  sign-extended instr[20:0]
//   offset out XLEN  sign-extended instr[25:0]
module decode_fields
  import decode_pkg::*;
#(
  parameter int IW   = 32,
  parameter int XLEN = 32
) (
  input  logic [IW-1:0]   instr,
  output dec_fields_t     fields,
  output logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] offset
);

  // Field extraction, sign extension and opcode classification.
  always_comb begin
    fields         = '0;
    fields.opcode  = instr[OPC_HI:OPC_LO];
    fields.rd      = instr[RD_HI:RD_LO];
    fields.rs      = instr[RS_HI:RS_LO];
    fields.shamt   = instr[SH_HI:SH_LO];
    fields.ext     = instr[EXT_HI:EXT_LO];
    fields.illegal = 1'b0;
    imm    = {{(XLEN-IMM_HI-1){instr[IMM_HI]}}, instr[IMM_HI:0]};
    offset = {{(XLEN-OFF_HI-1){instr[OFF_HI]}}, instr[OFF_HI:0]};
    case (instr[OPC_HI:OPC_LO])
      OP_ALU_R:  fields.cls = ALU_R;
      OP_ALU_I:  fields.cls = ALU_I;
      OP_LOAD:   fields.cls = LOAD;
      OP_STORE:  fields.cls = STORE;
      OP_BRANCH: fields.cls = BRANCH;
      OP_JUMP:   fields.cls = JUMP;
      default: begin
        fields.cls     = ILLEGAL;
        fields.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered KGP-RISC instruction decode with a 2-entry skid
// buffer and saturating decoded/illegal counters.
// Ports:
//   clk, rst (sync, active-high), flush
//   in_valid/in_ready/in_instr/in_pc       upstream handshake from fetch
//   out_valid/out_ready/out_*              decoded entry towards execute
//   decoded_cnt, illegal_cnt               saturating counts of output transfers
module decode_stage
  import decode_pkg::*;
#(
  parameter int IW   = 32,
  parameter int XLEN = 32,
  parameter int PCW  = 32,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IW-1:0]   in_instr,
  input  logic [PCW-1:0]  in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PCW-1:0]  out_pc,
  output logic [5:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs,
  output logic [4:0]      out_shamt,
  output logic [10:0]     out_ext,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_offset,
  output logic [2:0]      out_class,
  output logic            out_illegal,
  output logic [CNTW-1:0] decoded_cnt,
  output logic [CNTW-1:0] illegal_cnt
);

  typedef struct packed {
    logic [PCW-1:0]  pc;
    dec_fields_t     f;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] offset;
  } entry_t;

  entry_t          incoming;
  entry_t          main_entry;
  entry_t          skid_entry;
  logic            main_valid;
  logic            skid_valid;
  logic            in_fire;
  logic            out_fire;
  logic            main_free;
  dec_fields_t     dec_f;
  logic [XLEN-1:0] dec_imm;
  logic [XLEN-1:0] dec_offset;

  decode_fields #(.IW(IW), .XLEN(XLEN)) u_fields (
    .instr  (in_instr),
    .fields (dec_f),
    .imm    (dec_imm),
    .offset (dec_offset)
  );

  assign incoming = '{pc: in_pc, f: dec_f, imm: dec_imm, offset: dec_offset};

  // Ready depends only on state (and reset), never on out_ready.
  assign in_ready  = ~skid_valid & ~rst;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = main_valid & out_ready;
  // Main entry can take new data this edge: empty or being drained.
  assign main_free = ~main_valid | out_ready;

  // Skid buffer: main drives the outputs, skid absorbs one extra entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_entry <= '0;
      skid_entry <= '0;
    end else if (flush) begin
      // Data is left in place; only validity is dropped.
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (main_free) begin
      if (skid_valid) begin
        main_entry <= skid_entry;
        main_valid <= 1'b1;
        skid_valid <= in_fire;
        if (in_fire) begin
          skid_entry <= incoming;
        end
      end else begin
        main_valid <= in_fire;
        if (in_fire) begin
          main_entry <= incoming;
        end
      end
    end else if (in_fire) begin
      skid_entry <= incoming;
      skid_valid <= 1'b1;
    end
  end

  // Saturating counters; a transfer in a flush cycle still counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      decoded_cnt <= '0;
      illegal_cnt <= '0;
    end else if (out_fire) begin
      if (decoded_cnt != {CNTW{1'b1}}) begin
        decoded_cnt <= decoded_cnt + {{(CNTW-1){1'b0}}, 1'b1};
      end
      if (main_entry.f.illegal && (illegal_cnt != {CNTW{1'b1}})) begin
        illegal_cnt <= illegal_cnt + {{(CNTW-1){1'b0}}, 1'b1};
      end
    end
  end

  assign out_valid   = main_valid;
  assign out_pc      = main_entry.pc;
  assign out_opcode  = main_entry.f.opcode;
  assign out_rd      = main_entry.f.rd;
  assign out_rs      = main_entry.f.rs;
  assign out_shamt   = main_entry.f.shamt;
  assign out_ext     = main_entry.f.ext;
  assign out_imm     = main_entry.imm;
  assign out_offset  = main_entry.offset;
  assign out_class   = main_entry.f.cls;
  assign out_illegal = main_entry.f.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage (instantiated with CNTW=4).
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_pc, out_imm, out_offset;
  logic [5:0]  out_opcode;
  logic [4:0]  out_rd, out_rs, out_shamt;
  logic [10:0] out_ext;
  logic [2:0]  out_class;
  logic        out_illegal;
  logic [3:0]  decoded_cnt, illegal_cnt;
  int          checks = 0;
  int          errors = 0;

  decode_stage #(.IW(32), .XLEN(32), .PCW(32), .CNTW(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_opcode(out_opcode), .out_rd(out_rd), .out_rs(out_rs), .out_shamt(out_shamt),
    .out_ext(out_ext), .out_imm(out_imm), .out_offset(out_offset),
    .out_class(out_class), .out_illegal(out_illegal),
    .decoded_cnt(decoded_cnt), .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = 32'h0; in_pc = 32'h0;
    tick(); tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    in_instr = 32'h045FFFFF; in_pc = 32'h40;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %0b exp 0", in_ready); end
    checks++; if (out_pc !== 32'h0 || out_imm !== 32'h0 || out_opcode !== 6'd0)
      begin errors++; $display("FAIL reset_outs pc %h imm %h op %0d exp 0", out_pc, out_imm, out_opcode); end
    checks++; if (decoded_cnt !== 4'd0 || illegal_cnt !== 4'd0)
      begin errors++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", decoded_cnt, illegal_cnt); end
    in_valid = 1'b0; rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %0b exp 1", in_ready); end
  endtask

  task automatic test_alu_i();
    in_valid = 1'b1; in_instr = 32'h045FFFFF; in_pc = 32'h100; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL alu_i_valid got %0b exp 1", out_valid); end
    checks++; if (out_opcode !== 6'd1 || out_rd !== 5'd2 || out_rs !== 5'd31)
      begin errors++; $display("FAIL alu_i_fields op %0d rd %0d rs %0d exp 1 2 31", out_opcode, out_rd, out_rs); end
    checks++; if (out_imm !== 32'hFFFFFFFF) begin errors++; $display("FAIL alu_i_imm got %h exp ffffffff", out_imm); end
    checks++; if (out_class !== 3'd1 || out_illegal !== 1'b0)
      begin errors++; $display("FAIL alu_i_class got %0d ill %0b exp 1 0", out_class, out_illegal); end
    checks++; if (out_pc !== 32'h100) begin errors++; $display("FAIL alu_i_pc got %h exp 100", out_pc); end
    tick();
    checks++; if (out_valid !== 1'b0 || decoded_cnt !== 4'd1)
      begin errors++; $display("FAIL alu_i_drain valid %0b cnt %0d exp 0 1", out_valid, decoded_cnt); end
  endtask

  task automatic test_jump();
    out_ready = 1'b1; in_valid = 1'b1;
    in_instr = 32'h16000010; in_pc = 32'h104;
    tick();
    in_instr = 32'h14000010; in_pc = 32'h108;
    checks++; if (out_opcode !== 6'd5 || out_class !== 3'd5)
      begin errors++; $display("FAIL jump_class op %0d cls %0d exp 5 5", out_opcode, out_class); end
    checks++; if (out_offset !== 32'hFE000010) begin errors++; $display("FAIL jump_neg_off got %h exp fe000010", out_offset); end
    tick();
    in_valid = 1'b0;
    checks++; if (out_offset !== 32'h00000010 || out_pc !== 32'h108 || out_valid !== 1'b1)
      begin errors++; $display("FAIL jump_pos_off off %h pc %h v %0b exp 00000010 108 1", out_offset, out_pc, out_valid); end
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = 32'h00000001; in_pc = 32'h200;
    tick();
    checks++; if (out_pc !== 32'h200 || in_ready !== 1'b1)
      begin errors++; $display("FAIL bp_first pc %h rdy %0b exp 200 1", out_pc, in_ready); end
    in_instr = 32'h00000002; in_pc = 32'h204;
    tick();
    checks++; if (in_ready !== 1'b0 || out_pc !== 32'h200 || out_ext !== 11'd1)
      begin errors++; $display("FAIL bp_full rdy %0b pc %h ext %0d exp 0 200 1", in_ready, out_pc, out_ext); end
    in_instr = 32'h00000003; in_pc = 32'h208;
    tick();
    checks++; if (in_ready !== 1'b0 || out_pc !== 32'h200 || out_valid !== 1'b1)
      begin errors++; $display("FAIL bp_stable rdy %0b pc %h v %0b exp 0 200 1", in_ready, out_pc, out_valid); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_pc !== 32'h204 || out_ext !== 11'd2 || in_ready !== 1'b1)
      begin errors++; $display("FAIL bp_out1 pc %h ext %0d rdy %0b exp 204 2 1", out_pc, out_ext, in_ready); end
    tick();
    checks++; if (out_pc !== 32'h208 || out_ext !== 11'd3)
      begin errors++; $display("FAIL bp_out2 pc %h ext %0d exp 208 3", out_pc, out_ext); end
    in_instr = 32'h00000004; in_pc = 32'h20C;
    tick();
    in_valid = 1'b0;
    checks++; if (out_pc !== 32'h20C || out_ext !== 11'd4 || out_valid !== 1'b1)
      begin errors++; $display("FAIL bp_out3 pc %h ext %0d v %0b exp 20c 4 1", out_pc, out_ext, out_valid); end
    tick();
    checks++; if (out_valid !== 1'b0 || decoded_cnt !== 4'd4)
      begin errors++; $display("FAIL bp_done v %0b cnt %0d exp 0 4", out_valid, decoded_cnt); end
  endtask

  task automatic test_flush();
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = 32'h04000000; in_pc = 32'h300; tick();
    in_pc = 32'h304; tick();
    in_pc = 32'h308; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || decoded_cnt !== 4'd0)
      begin errors++; $display("FAIL flush_full v %0b rdy %0b cnt %0d exp 0 1 0", out_valid, in_ready, decoded_cnt); end
    out_ready = 1'b1;
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_gone v %0b exp 0", out_valid); end
    // Single entry held, new input accepted in flush cycle: both dropped.
    out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h310; tick();
    in_pc = 32'h314; flush = 1'b1; tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin errors++; $display("FAIL flush_drop v %0b rdy %0b exp 0 1", out_valid, in_ready); end
    // Transfer in the flush cycle still counts.
    in_valid = 1'b1; in_pc = 32'h320; tick();
    in_valid = 1'b0; out_ready = 1'b1; flush = 1'b1; tick();
    flush = 1'b0;
    checks++; if (out_valid !== 1'b0 || decoded_cnt !== 4'd1)
      begin errors++; $display("FAIL flush_xfer v %0b cnt %0d exp 0 1", out_valid, decoded_cnt); end
  endtask

  task automatic test_illegal();
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'hFC000000; in_pc = 32'h400;
    tick();
    in_valid = 1'b0;
    checks++; if (out_illegal !== 1'b1 || out_class !== 3'd7 || out_opcode !== 6'h3F)
      begin errors++; $display("FAIL illegal_dec ill %0b cls %0d op %h exp 1 7 3f", out_illegal, out_class, out_opcode); end
    checks++; if (decoded_cnt !== 4'd0 || illegal_cnt !== 4'd0)
      begin errors++; $display("FAIL illegal_nocnt got %0d/%0d exp 0/0", decoded_cnt, illegal_cnt); end
    out_ready = 1'b1;
    tick();
    checks++; if (decoded_cnt !== 4'd1 || illegal_cnt !== 4'd1)
      begin errors++; $display("FAIL illegal_cnt got %0d/%0d exp 1/1", decoded_cnt, illegal_cnt); end
  endtask

  task automatic test_saturation();
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_instr = (i % 2 == 0) ? 32'hFC000000 : 32'h08000000;
      in_pc = 32'h500 + 32'(i * 4);
      tick();
      if (i == 9) begin
        // 9 transfers so far (first edge only loads main); 5 illegal ones.
        checks++; if (decoded_cnt !== 4'd9 || illegal_cnt !== 4'd5)
          begin errors++; $display("FAIL sat_mid got %0d/%0d exp 9/5", decoded_cnt, illegal_cnt); end
        checks++; if (out_pc !== 32'h524) begin errors++; $display("FAIL sat_mid_pc got %h exp 524", out_pc); end
      end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (decoded_cnt !== 4'd15 || illegal_cnt !== 4'd10)
      begin errors++; $display("FAIL sat_end got %0d/%0d exp 15/10", decoded_cnt, illegal_cnt); end
    // Reset mid-stream with an entry held.
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'hFC000000; tick(); tick();
    rst = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %0b exp 0", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0 || decoded_cnt !== 4'd0 || illegal_cnt !== 4'd0 || out_pc !== 32'h0 || out_illegal !== 1'b0)
      begin errors++; $display("FAIL rst_mid v %0b cnt %0d/%0d pc %h ill %0b exp all 0", out_valid, decoded_cnt, illegal_cnt, out_pc, out_illegal); end
    rst = 1'b0; in_valid = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_alu_i();
    test_jump();
    test_backpressure();
    test_flush();
    test_illegal();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
